// File: rtl/irl_refill.sv
// irl_refill: periodic token-bucket refill engine.
// On each refill_tick it sweeps every flow index, reads the flow's bucket and
// its source record, fetches the CIR/EIR limiting profiles of the flow's
// limiter, and writes back the bucket with each token count raised by the
// profile increment and clamped at the profile maximum. A policer write to
// the flow being refilled discards the in-flight data and restarts that flow.

`ifndef FLOW_VALUE_DEPTH_NBITS
`define FLOW_VALUE_DEPTH_NBITS 4
`endif
`ifndef CIR_NBITS
`define CIR_NBITS 8
`endif
`ifndef EIR_NBITS
`define EIR_NBITS 8
`endif
`ifndef LIMITER_NBITS
`define LIMITER_NBITS 4
`endif
`ifndef FILL_TB_NBITS
`define FILL_TB_NBITS (`LIMITER_NBITS+1)
`endif
`ifndef LIMITING_PROFILE_NBITS
`define LIMITING_PROFILE_NBITS (2*`CIR_NBITS)
`endif

module irl_refill #(
  parameter int DEPTH_NBITS  = `FLOW_VALUE_DEPTH_NBITS,
  parameter int CIR_TB_NBITS = `CIR_NBITS + 2,
  parameter int EIR_TB_NBITS = `EIR_NBITS + 2,
  parameter int BUCKET_NBITS = CIR_TB_NBITS + EIR_TB_NBITS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               refill_tick,
  output logic                               token_bucket_rd,
  output logic [DEPTH_NBITS-1:0]             token_bucket_raddr,
  input  logic                               token_bucket_ack,
  input  logic [BUCKET_NBITS-1:0]            token_bucket_rdata,
  output logic                               fill_tb_src_rd,
  output logic [DEPTH_NBITS-1:0]             fill_tb_src_raddr,
  input  logic                               fill_tb_src_ack,
  input  logic [`FILL_TB_NBITS-1:0]          fill_tb_src_rdata,
  output logic                               limiting_profile_cir_rd,
  output logic [`LIMITER_NBITS-1:0]          limiting_profile_cir_raddr,
  input  logic                               limiting_profile_cir_ack,
  input  logic [`LIMITING_PROFILE_NBITS-1:0] limiting_profile_cir_rdata,
  output logic                               limiting_profile_eir_rd,
  output logic [`LIMITER_NBITS-1:0]          limiting_profile_eir_raddr,
  input  logic                               limiting_profile_eir_ack,
  input  logic [`LIMITING_PROFILE_NBITS-1:0] limiting_profile_eir_rdata,
  input  logic                               policer_wr,
  input  logic [DEPTH_NBITS-1:0]             policer_waddr,
  output logic                               token_bucket_wr,
  output logic [DEPTH_NBITS-1:0]             token_bucket_waddr,
  output logic [BUCKET_NBITS-1:0]            token_bucket_wdata,
  output logic                               refill_busy,
  output logic                               refill_done,
  output logic                               refill_overrun,
  output logic [2:0]                         dbg_state_o
);

  // Read/ack handshake: every rd is a single-cycle request carrying its
  // address; the responder later returns exactly one single-cycle ack with
  // the data. A new rd on a port is only issued once the previous one on
  // that port has been acked, so stale acks after a restart are drained
  // before the flow is re-read.

  localparam int LIM_W  = `LIMITER_NBITS;
  localparam int SRC_W  = `FILL_TB_NBITS;
  localparam int PROF_W = `LIMITING_PROFILE_NBITS;
  localparam int CIR_W  = `CIR_NBITS;
  localparam int EIR_W  = `EIR_NBITS;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_SRC  = 3'd1;
  localparam logic [2:0] ST_WT_SRC  = 3'd2;
  localparam logic [2:0] ST_RD_PROF = 3'd3;
  localparam logic [2:0] ST_WT_PROF = 3'd4;
  localparam logic [2:0] ST_WR      = 3'd5;

  logic [2:0]              state_q, state_d;
  logic [DEPTH_NBITS-1:0]  idx_q, idx_d;
  logic                    tb_pend_q, src_pend_q, cir_pend_q, eir_pend_q;
  logic [BUCKET_NBITS-1:0] bkt_q;
  logic [SRC_W-1:0]        src_q;
  logic [PROF_W-1:0]       cir_prof_q, eir_prof_q;
  logic                    done_q, done_d;
  logic                    overrun_q;

  logic                    hazard;
  logic                    issue_src;
  logic                    issue_prof;
  logic                    flow_end;

  logic [CIR_TB_NBITS-1:0] cir_tok, cir_new;
  logic [EIR_TB_NBITS-1:0] eir_tok, eir_new;
  logic [CIR_TB_NBITS:0]   cir_sum, cir_cap;
  logic [EIR_TB_NBITS:0]   eir_sum, eir_cap;

  // Handshake qualifiers: a policer write to the current flow invalidates
  // any in-flight data for it.
  always_comb begin
    hazard     = policer_wr && (policer_waddr == idx_q) && (state_q != ST_IDLE);
    issue_src  = (state_q == ST_RD_SRC) && !hazard &&
                 !tb_pend_q && !src_pend_q && !cir_pend_q && !eir_pend_q;
    issue_prof = (state_q == ST_RD_PROF) && !hazard;
  end

  // Sweep sequencing: next state, flow index and end-of-sweep pulse.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    flow_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // a tick coinciding with the done pulse is an overrun, not a start
        if (refill_tick && !done_q) begin
          idx_d   = '0;
          state_d = ST_RD_SRC;
        end
      end
      ST_RD_SRC: begin
        if (issue_src) state_d = ST_WT_SRC;
      end
      ST_WT_SRC: begin
        if (hazard) begin
          state_d = ST_RD_SRC;
        end else if (!tb_pend_q && !src_pend_q) begin
          if (src_q[SRC_W-1]) state_d = ST_RD_PROF;
          else                flow_end = 1'b1;
        end
      end
      ST_RD_PROF: begin
        state_d = hazard ? ST_RD_SRC : ST_WT_PROF;
      end
      ST_WT_PROF: begin
        if (hazard)                           state_d = ST_RD_SRC;
        else if (!cir_pend_q && !eir_pend_q)  state_d = ST_WR;
      end
      ST_WR: begin
        if (hazard)           state_d = ST_RD_SRC;
        else if (!policer_wr) flow_end = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flow_end) begin
      if (idx_q == {DEPTH_NBITS{1'b1}}) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        idx_d   = idx_q + DEPTH_NBITS'(1);
        state_d = ST_RD_SRC;
      end
    end
  end

  // Refill arithmetic: saturating add against the profile maximum, with a
  // one-bit-wider sum so the addition can never wrap.
  always_comb begin
    cir_tok = bkt_q[BUCKET_NBITS-1 -: CIR_TB_NBITS];
    eir_tok = bkt_q[EIR_TB_NBITS-1:0];
    cir_sum = {1'b0, cir_tok} + (CIR_TB_NBITS+1)'(cir_prof_q[CIR_W-1:0]);
    cir_cap = (CIR_TB_NBITS+1)'(cir_prof_q[2*CIR_W-1:CIR_W]);
    eir_sum = {1'b0, eir_tok} + (EIR_TB_NBITS+1)'(eir_prof_q[EIR_W-1:0]);
    eir_cap = (EIR_TB_NBITS+1)'(eir_prof_q[2*EIR_W-1:EIR_W]);
    cir_new = (cir_sum < cir_cap) ? cir_sum[CIR_TB_NBITS-1:0] : cir_cap[CIR_TB_NBITS-1:0];
    eir_new = (eir_sum < eir_cap) ? eir_sum[EIR_TB_NBITS-1:0] : eir_cap[EIR_TB_NBITS-1:0];
  end

  // FSM state, index and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      overrun_q <= refill_tick && ((state_q != ST_IDLE) || done_q);
    end
  end

  // Outstanding-read tracking per port: set on issue, cleared by the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_pend_q  <= 1'b0;
      src_pend_q <= 1'b0;
      cir_pend_q <= 1'b0;
      eir_pend_q <= 1'b0;
    end else begin
      if (issue_src)                     tb_pend_q  <= 1'b1;
      else if (token_bucket_ack)         tb_pend_q  <= 1'b0;
      if (issue_src)                     src_pend_q <= 1'b1;
      else if (fill_tb_src_ack)          src_pend_q <= 1'b0;
      if (issue_prof)                    cir_pend_q <= 1'b1;
      else if (limiting_profile_cir_ack) cir_pend_q <= 1'b0;
      if (issue_prof)                    eir_pend_q <= 1'b1;
      else if (limiting_profile_eir_ack) eir_pend_q <= 1'b0;
    end
  end

  // Read-data capture: each return is latched on its own ack while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bkt_q      <= '0;
      src_q      <= '0;
      cir_prof_q <= '0;
      eir_prof_q <= '0;
    end else begin
      if (state_q == ST_WT_SRC && token_bucket_ack)          bkt_q      <= token_bucket_rdata;
      if (state_q == ST_WT_SRC && fill_tb_src_ack)           src_q      <= fill_tb_src_rdata;
      if (state_q == ST_WT_PROF && limiting_profile_cir_ack) cir_prof_q <= limiting_profile_cir_rdata;
      if (state_q == ST_WT_PROF && limiting_profile_eir_ack) eir_prof_q <= limiting_profile_eir_rdata;
    end
  end

  // Output drive: requests are decoded from the state so they vanish with it.
  always_comb begin
    token_bucket_rd            = issue_src;
    token_bucket_raddr         = idx_q;
    fill_tb_src_rd             = issue_src;
    fill_tb_src_raddr          = idx_q;
    limiting_profile_cir_rd    = issue_prof;
    limiting_profile_cir_raddr = src_q[LIM_W-1:0];
    limiting_profile_eir_rd    = issue_prof;
    limiting_profile_eir_raddr = src_q[LIM_W-1:0];
    token_bucket_wr            = (state_q == ST_WR) && !policer_wr;
    token_bucket_waddr         = idx_q;
    token_bucket_wdata         = {cir_new, eir_new};
    refill_busy                = (state_q != ST_IDLE);
    refill_done                = done_q;
    refill_overrun             = overrun_q;
    dbg_state_o                = state_q;
  end

endmodule

// File: doc/irl_refill.md
IRL_REFILL -- requirements
Module: irl_refill

Interface
REQ-001 SHALL have parameter DEPTH_NBITS, default `FLOW_VALUE_DEPTH_NBITS; flow-index width, sweep covers 0..2^DEPTH_NBITS-1.
REQ-002 SHALL have parameters CIR_TB_NBITS, default `CIR_NBITS+2, and EIR_TB_NBITS, default `EIR_NBITS+2; these are the bucket field widths.
REQ-003 SHALL have parameter BUCKET_NBITS, default CIR_TB_NBITS+EIR_TB_NBITS; bucket word = {cir_tok, eir_tok}, with cir_tok in the MSBs.
REQ-004 SHALL use one clock and an asynchronous active-high reset, with ports ordered as below:
 clk  in  1  sole clock
 `RESET_SIG  in  1  asynchronous, active-high reset
 refill_tick  in  1  one-cycle pulse that starts a sweep
 token_bucket_rd / token_bucket_raddr  out  1 / DEPTH_NBITS  bucket read
 token_bucket_ack / token_bucket_rdata  in  1 / BUCKET_NBITS  bucket read return
 fill_tb_src_rd / fill_tb_src_raddr  out  1 / DEPTH_NBITS  source read
 fill_tb_src_ack / fill_tb_src_rdata  in  1 / `FILL_TB_NBITS  source return; bit MSB = valid, [`LIMITER_NBITS-1:0] = limiter id
 limiting_profile_cir_rd / limiting_profile_cir_raddr  out  1 / `LIMITER_NBITS  CIR profile read
 limiting_profile_cir_ack / limiting_profile_cir_rdata  in  1 / `LIMITING_PROFILE_NBITS  CIR profile {max, inc}, inc in the LSBs, `CIR_NBITS wide
 limiting_profile_eir_rd / limiting_profile_eir_raddr / limiting_profile_eir_ack / limiting_profile_eir_rdata  same layout as the CIR profile ports, for EIR
 policer_wr / policer_waddr  in  1 / DEPTH_NBITS  competing token_bucket write from the policer
 token_bucket_wr / token_bucket_waddr / token_bucket_wdata  out  1 / DEPTH_NBITS / BUCKET_NBITS  refill write
 refill_busy  out  1  high while a sweep is in progress
 refill_done  out  1  one-cycle pulse when a sweep ends
 refill_overrun  out  1  one-cycle pulse when a tick arrives while busy

Function
REQ-005 SHALL implement the states IDLE, RD_SRC, WT_SRC, RD_PROF, WT_PROF, WR.
REQ-006 IDLE: on refill_tick, SHALL set idx=0 and move to RD_SRC.
REQ-007 RD_SRC: SHALL pulse token_bucket_rd and fill_tb_src_rd for one cycle, with both raddr=idx, then move to WT_SRC.
REQ-008 WT_SRC: SHALL latch each rdata on its own ack; acks may arrive in different cycles; SHALL stay in WT_SRC until both have arrived.
REQ-009 After both acks: if src valid=0, SHALL skip the flow with no write; otherwise SHALL go to RD_PROF.
REQ-010 RD_PROF: SHALL pulse both profile rd for one cycle, raddr=limiter id, then go to WT_PROF.
REQ-011 WT_PROF: SHALL wait, with no timeout, for both profile acks (PIO arbitration may delay them).
REQ-012 WR: SHALL compute cir_new = min(cir_tok + zero-extended cir_inc, cir_max), with the sum one bit wider so it cannot wrap; eir_new likewise.
REQ-013 WR: SHALL assert token_bucket_wr, waddr=idx, wdata={cir_new, eir_new}, only in a cycle where policer_wr=0; otherwise it SHALL hold in WR.
REQ-014 Hazard: if policer_wr with policer_waddr==idx occurs in any cycle from RD_SRC through WR (including the WR-stall cycle), SHALL discard the latched data, perform no write, and return to RD_SRC for the same idx.
REQ-015 Flow complete (written or skipped): if idx = all-ones, SHALL pulse refill_done and go to IDLE; else idx+1 and go to RD_SRC.
REQ-016 refill_busy SHALL be 1 in every state except IDLE.
REQ-017 refill_tick while not IDLE SHALL be ignored for the sweep and SHALL pulse refill_overrun the next cycle.
REQ-018 A tick in the same cycle as refill_done SHALL count as an overrun and SHALL NOT start a new sweep.
REQ-019 Every rd and wr SHALL be at most one cycle wide, and no rd SHALL be reissued before its ack.

Reset
REQ-020 `RESET_SIG SHALL drive state=IDLE, idx=0, and all rd, wr, refill_busy, refill_done and refill_overrun outputs to 0; addr/data outputs SHALL be 0.
REQ-021 Reset mid-sweep SHALL abandon the sweep; no partial write SHALL follow deassertion.

Verification
REQ-022 DEPTH_NBITS=2, all flows valid, limiter 0, cir inc=5 max=20, buckets cir=3 -> four writes with cir=8, idx 0..3, then refill_done once.
REQ-023 Bucket cir=18, inc=5, max=20 -> written cir=20; bucket already at max=20 -> written cir=20, unchanged.
REQ-024 Flow 2 src valid=0 -> no profile read and no write for idx 2; flows 0, 1, 3 written.
REQ-025 policer_wr waddr=1 while in WT_PROF for idx 1 -> idx 1 re-read, one write only; policer_wr waddr=3 during idx 1 WR -> write stalled one cycle, no re-read.
REQ-026 Profile acks delayed 7 cycles and token_bucket_ack 3 cycles after fill_tb_src_ack -> correct data, no duplicate rd.
REQ-027 refill_tick mid-sweep -> refill_overrun pulse, sweep unaffected; reset asserted in WR -> no write, busy=0.
